// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS commit trace recorder.
//  - evt_code_e   : record class codes, also the fixed classification priority
//                   (lower code wins when several events retire in one cycle)
//  - trace_state_e: capture state machine encodings
//  - record layout: {code, reg, data, pc} with pc in the least significant bits
package mips_trace_pkg;

  localparam int CODE_W = 2;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    EVT_REGWR  = 2'd0,
    EVT_STORE  = 2'd1,
    EVT_BRANCH = 2'd2,
    EVT_JUMP   = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  // Field offsets inside a record, counted from bit 0.
  function automatic int pc_lsb();
    return 0;
  endfunction

  function automatic int data_lsb(input int pc_w);
    return pc_w;
  endfunction

  function automatic int reg_lsb(input int data_w, input int pc_w);
    return data_w + pc_w;
  endfunction

  function automatic int code_lsb(input int data_w, input int pc_w);
    return REG_W + data_w + pc_w;
  endfunction

  function automatic int rec_width(input int data_w, input int pc_w);
    return CODE_W + REG_W + data_w + pc_w;
  endfunction

endpackage

// File: rtl/trace_sat_counter.sv
// Saturating event counter used for the per-class and drop statistics.
// Ports:
//   Clk, Reset : clock, synchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   count      : current value, sticks at all-ones
module trace_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement-event recorder for the 5-stage MIPS pipeline.
// Each cycle the WB/MEM/ID commit taps are reduced to at most one record,
// which is pushed into a DEPTH-entry circular buffer while capture is armed.
// A PC-match trigger starts a post-trigger window after which capture freezes.
// Ports:
//   Clk, Reset          : clock, synchronous active-low reset
//   En, Clear           : arm capture / clear everything back to idle
//   WB_*, MEM_*, ID_*   : pipeline commit taps; PC is logged with every record
//   TrigEn/TrigPC       : PC-match trigger; PostCnt records follow the trigger
//   Rd_Valid/Rd_Ready   : head-of-buffer read handshake, Rd_Data is the head
//   Count               : occupied entries
//   Cnt_Evt, Cnt_Drop   : {jump,branch,store,regwr} and drop counters
//   Frozen              : capture has stopped after the trigger window
module commit_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              En,
  input  logic                              Clear,
  input  logic                              WB_RegWrite,
  input  logic [4:0]                        WB_WriteReg,
  input  logic [DATA_W-1:0]                 WB_WriteData,
  input  logic                              MEM_MemWrite,
  input  logic                              ID_BranchTaken,
  input  logic                              ID_DoJump,
  input  logic [PC_W-1:0]                   PC,
  input  logic                              TrigEn,
  input  logic [PC_W-1:0]                   TrigPC,
  input  logic [$clog2(DEPTH):0]            PostCnt,
  output logic                              Rd_Valid,
  input  logic                              Rd_Ready,
  output logic [2+5+DATA_W+PC_W-1:0]        Rd_Data,
  output logic [$clog2(DEPTH):0]            Count,
  output logic [4*CNT_W-1:0]                Cnt_Evt,
  output logic [CNT_W-1:0]                  Cnt_Drop,
  output logic                              Frozen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = rec_width(DATA_W, PC_W);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  trace_state_e     state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d, remain_q, remain_d;
  logic             frozen_q, frozen_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];

  evt_code_e        evt_code;
  logic [4:0]       evt_reg;
  logic [DATA_W-1:0] evt_data;
  logic             evt_any;
  logic [REC_W-1:0] rec_data;
  logic             capturing, record, pop, full, overwrite, drop, push;

  // Fixed-priority reduction of the commit taps; reg/data only mean
  // something for register writes and are zeroed for the other classes.
  always_comb begin
    evt_code = EVT_JUMP;
    evt_reg  = '0;
    evt_data = '0;
    evt_any  = 1'b1;
    if (WB_RegWrite) begin
      evt_code = EVT_REGWR;
      evt_reg  = WB_WriteReg;
      evt_data = WB_WriteData;
    end else if (MEM_MemWrite) begin
      evt_code = EVT_STORE;
    end else if (ID_BranchTaken) begin
      evt_code = EVT_BRANCH;
    end else if (ID_DoJump) begin
      evt_code = EVT_JUMP;
    end else begin
      evt_any = 1'b0;
    end
  end

  assign rec_data  = {evt_code, evt_reg, evt_data, PC};
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign record    = capturing && evt_any;
  assign Rd_Valid  = (count_q != '0);
  assign pop       = Rd_Valid && Rd_Ready;
  assign full      = (count_q == FULL_COUNT);
  // A same-cycle pop makes room, so only a push without pop into a full
  // buffer is lost (stop mode) or evicts the oldest entry (wrap mode).
  assign drop      = record && full && !pop;
  assign overwrite = drop && (WRAP_MODE != 0);
  assign push      = record && (!full || pop || overwrite);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (Clear) begin
      state_d  = ST_IDLE;
      remain_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (En) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (record && TrigEn && (PC == TrigPC)) begin
            if (PostCnt == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d  = ST_POST;
              remain_d = PostCnt;
            end
          end
        end
        ST_POST: begin
          // Dropped records still consume the post-trigger window.
          if (record) begin
            remain_d = remain_q - CNT_ONE;
            if (remain_q == CNT_ONE) state_d = ST_FROZEN;
          end
        end
        default: begin
        end
      endcase
      if (push) begin
        mem_d[wr_ptr_q] = rec_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop || overwrite) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop && !overwrite) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
    frozen_d = (state_d == ST_FROZEN);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      frozen_q <= frozen_d;
    end
  end

  // Storage needs no reset: the read port is gated by Rd_Valid.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign Rd_Data = Rd_Valid ? mem_q[rd_ptr_q] : '0;
  assign Count   = count_q;
  assign Frozen  = frozen_q;

  // One counter per class, packed {jump,branch,store,regwr} by code.
  for (genvar i = 0; i < 4; i++) begin : g_evt
    trace_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (record && (evt_code == evt_code_e'(i))),
      .clr   (Clear),
      .count (Cnt_Evt[i*CNT_W +: CNT_W])
    );
  end

  trace_sat_counter #(.CNT_W(CNT_W)) u_cnt_drop (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (drop),
    .clr   (Clear),
    .count (Cnt_Drop)
  );

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: a stop-when-full and an overwrite instance
// (both DEPTH=4) share one stimulus; each has its own expected-record queue
// that is filled as events are driven and emptied as the buffer is drained.
module tb_commit_trace_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 16;
  localparam int REC_W  = 2 + 5 + DATA_W + PC_W;

  logic              Clk = 1'b0;
  logic              Reset, En, Clear;
  logic              WB_RegWrite;
  logic [4:0]        WB_WriteReg;
  logic [DATA_W-1:0] WB_WriteData;
  logic              MEM_MemWrite, ID_BranchTaken, ID_DoJump;
  logic [PC_W-1:0]   PC;
  logic              TrigEn;
  logic [PC_W-1:0]   TrigPC;
  logic [2:0]        PostCnt;
  logic              Rd_Ready;

  logic [1:0]                  rd_valid;
  logic [1:0][REC_W-1:0]       rd_data;
  logic [1:0][2:0]             count;
  logic [1:0][4*CNT_W-1:0]     cnt_evt;
  logic [1:0][CNT_W-1:0]       cnt_drop;
  logic [1:0]                  frozen;

  int total = 0;
  int bad   = 0;
  logic [REC_W-1:0] exp0[$];
  logic [REC_W-1:0] exp1[$];
  int drop_exp0 = 0;
  int drop_exp1 = 0;

  always #5 Clk = ~Clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W), .WRAP_MODE(0)) dut_stop (
    .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .MEM_MemWrite(MEM_MemWrite), .ID_BranchTaken(ID_BranchTaken), .ID_DoJump(ID_DoJump),
    .PC(PC), .TrigEn(TrigEn), .TrigPC(TrigPC), .PostCnt(PostCnt),
    .Rd_Valid(rd_valid[0]), .Rd_Ready(Rd_Ready), .Rd_Data(rd_data[0]), .Count(count[0]),
    .Cnt_Evt(cnt_evt[0]), .Cnt_Drop(cnt_drop[0]), .Frozen(frozen[0])
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W), .WRAP_MODE(1)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .En(En), .Clear(Clear),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .MEM_MemWrite(MEM_MemWrite), .ID_BranchTaken(ID_BranchTaken), .ID_DoJump(ID_DoJump),
    .PC(PC), .TrigEn(TrigEn), .TrigPC(TrigPC), .PostCnt(PostCnt),
    .Rd_Valid(rd_valid[1]), .Rd_Ready(Rd_Ready), .Rd_Data(rd_data[1]), .Count(count[1]),
    .Cnt_Evt(cnt_evt[1]), .Cnt_Drop(cnt_drop[1]), .Frozen(frozen[1])
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_events();
    WB_RegWrite    = 1'b0;
    WB_WriteReg    = '0;
    WB_WriteData   = '0;
    MEM_MemWrite   = 1'b0;
    ID_BranchTaken = 1'b0;
    ID_DoJump      = 1'b0;
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [1:0] code, input logic [4:0] rg,
                                              input logic [31:0] data, input logic [31:0] pc);
    return {code, rg, data, pc};
  endfunction

  // Reference behaviour of a 4-entry buffer in both full-handling modes.
  task automatic push_exp(input logic [REC_W-1:0] r);
    if (exp0.size() < DEPTH) exp0.push_back(r);
    else drop_exp0++;
    if (exp1.size() == DEPTH) begin
      exp1.delete(0);
      drop_exp1++;
    end
    exp1.push_back(r);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    cycle();
    Clear = 1'b0;
    exp0.delete();
    exp1.delete();
    drop_exp0 = 0;
    drop_exp1 = 0;
  endtask

  task automatic arm();
    En = 1'b1;
    cycle();
    En = 1'b0;
  endtask

  task automatic test_reset();
    arm();
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd3; WB_WriteData = 32'hAA; PC = 32'h40;
    cycle();
    idle_events();
    MEM_MemWrite = 1'b1; PC = 32'h44;
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd2) begin
        bad++; $display("[TB] FAIL pre_reset_count dut%0d: got %0d expected 2", d, count[d]);
      end
    end
    // Event stays asserted through reset and the first idle cycle after it.
    Reset = 1'b0;
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd0) begin
        bad++; $display("[TB] FAIL reset_count dut%0d: got %0d expected 0", d, count[d]);
      end
      total++;
      if (rd_valid[d] !== 1'b0 || rd_data[d] !== '0) begin
        bad++; $display("[TB] FAIL reset_read dut%0d: got valid=%b data=%h expected 0", d, rd_valid[d], rd_data[d]);
      end
      total++;
      if (cnt_evt[d] !== '0 || cnt_drop[d] !== '0) begin
        bad++; $display("[TB] FAIL reset_counters dut%0d: got evt=%h drop=%h expected 0", d, cnt_evt[d], cnt_drop[d]);
      end
      total++;
      if (frozen[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_frozen dut%0d: got %b expected 0", d, frozen[d]);
      end
    end
    Reset = 1'b1;
    cycle();
    idle_events();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd0) begin
        bad++; $display("[TB] FAIL idle_no_capture dut%0d: got %0d expected 0", d, count[d]);
      end
    end
  endtask

  task automatic test_priority();
    int n;
    logic [REC_W-1:0] e;
    arm();
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd9; WB_WriteData = 32'd1; MEM_MemWrite = 1'b1; PC = 32'h4;
    push_exp(mk_rec(2'd0, 5'd9, 32'd1, 32'h4));
    cycle();
    idle_events();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd1) begin
        bad++; $display("[TB] FAIL prio_count dut%0d: got %0d expected 1", d, count[d]);
      end
      total++;
      if (cnt_evt[d][15:0] !== 16'd1 || cnt_evt[d][31:16] !== 16'd0) begin
        bad++; $display("[TB] FAIL prio_counters dut%0d: got regwr=%0d store=%0d expected 1/0", d, cnt_evt[d][15:0], cnt_evt[d][31:16]);
      end
    end
    Rd_Ready = 1'b1;
    for (int c = 0; c < 12 && (exp0.size() > 0 || exp1.size() > 0); c++) begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? exp0.size() : exp1.size();
        if (n > 0) begin
          if (d == 0) begin e = exp0[0]; exp0.delete(0); end
          else begin e = exp1[0]; exp1.delete(0); end
          total++;
          if (rd_valid[d] !== 1'b1 || rd_data[d] !== e) begin
            bad++; $display("[TB] FAIL prio_drain dut%0d: got valid=%b data=%h expected %h", d, rd_valid[d], rd_data[d], e);
          end
        end
      end
      cycle();
    end
    Rd_Ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rd_valid[d] !== 1'b0 || count[d] !== 3'd0) begin
        bad++; $display("[TB] FAIL prio_empty dut%0d: got valid=%b count=%0d expected 0/0", d, rd_valid[d], count[d]);
      end
    end
    do_clear();
  endtask

  task automatic test_full_wrap();
    int n;
    logic [REC_W-1:0] e;
    arm();
    // Stale WB fields must not leak into store records.
    WB_WriteReg = 5'd7; WB_WriteData = 32'hDEAD;
    for (int i = 1; i <= 6; i++) begin
      MEM_MemWrite = 1'b1;
      PC = 32'h100 + 32'(i);
      push_exp(mk_rec(2'd1, 5'd0, 32'd0, PC));
      cycle();
    end
    idle_events();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd4) begin
        bad++; $display("[TB] FAIL full_count dut%0d: got %0d expected 4", d, count[d]);
      end
      total++;
      if (cnt_drop[d] !== CNT_W'((d == 0) ? drop_exp0 : drop_exp1)) begin
        bad++; $display("[TB] FAIL full_drop dut%0d: got %0d expected %0d", d, cnt_drop[d], (d == 0) ? drop_exp0 : drop_exp1);
      end
      total++;
      if (cnt_evt[d][31:16] !== 16'd6) begin
        bad++; $display("[TB] FAIL full_store_cnt dut%0d: got %0d expected 6", d, cnt_evt[d][31:16]);
      end
    end
    Rd_Ready = 1'b1;
    for (int c = 0; c < 12 && (exp0.size() > 0 || exp1.size() > 0); c++) begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? exp0.size() : exp1.size();
        if (n > 0) begin
          if (d == 0) begin e = exp0[0]; exp0.delete(0); end
          else begin e = exp1[0]; exp1.delete(0); end
          total++;
          if (rd_valid[d] !== 1'b1 || rd_data[d] !== e) begin
            bad++; $display("[TB] FAIL full_drain dut%0d: got valid=%b data=%h expected %h", d, rd_valid[d], rd_data[d], e);
          end
        end
      end
      cycle();
    end
    Rd_Ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rd_valid[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL full_empty dut%0d: got valid=%b expected 0", d, rd_valid[d]);
      end
    end
    do_clear();
  endtask

  task automatic test_trigger();
    int n;
    logic [REC_W-1:0] e;
    logic [31:0] pcs [6];
    pcs = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    TrigEn = 1'b1; TrigPC = 32'h0C; PostCnt = 3'd2;
    arm();
    for (int i = 0; i < 5; i++) begin
      ID_BranchTaken = 1'b1;
      ID_DoJump = i[0];
      PC = pcs[i];
      push_exp(mk_rec(2'd2, 5'd0, 32'd0, pcs[i]));
      cycle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (frozen[d] !== (pcs[i] == 32'h14)) begin
          bad++; $display("[TB] FAIL trig_frozen dut%0d pc=%h: got %b expected %b", d, pcs[i], frozen[d], pcs[i] == 32'h14);
        end
      end
    end
    ID_BranchTaken = 1'b1; ID_DoJump = 1'b0; PC = pcs[5];
    cycle();
    idle_events();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd4 || cnt_evt[d][47:32] !== 16'd5 || cnt_evt[d][63:48] !== 16'd0) begin
        bad++; $display("[TB] FAIL trig_after dut%0d: got count=%0d branch=%0d jump=%0d expected 4/5/0", d, count[d], cnt_evt[d][47:32], cnt_evt[d][63:48]);
      end
      total++;
      if (cnt_drop[d] !== 16'd1) begin
        bad++; $display("[TB] FAIL trig_drop dut%0d: got %0d expected 1", d, cnt_drop[d]);
      end
    end
    Rd_Ready = 1'b1;
    for (int c = 0; c < 12 && (exp0.size() > 0 || exp1.size() > 0); c++) begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? exp0.size() : exp1.size();
        if (n > 0) begin
          if (d == 0) begin e = exp0[0]; exp0.delete(0); end
          else begin e = exp1[0]; exp1.delete(0); end
          total++;
          if (rd_valid[d] !== 1'b1 || rd_data[d] !== e) begin
            bad++; $display("[TB] FAIL trig_drain dut%0d: got valid=%b data=%h expected %h", d, rd_valid[d], rd_data[d], e);
          end
        end
      end
      cycle();
    end
    Rd_Ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rd_valid[d] !== 1'b0 || frozen[d] !== 1'b1) begin
        bad++; $display("[TB] FAIL trig_drained dut%0d: got valid=%b frozen=%b expected 0/1", d, rd_valid[d], frozen[d]);
      end
    end
    do_clear();
    TrigEn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (frozen[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL trig_clear dut%0d: got frozen=%b expected 0", d, frozen[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [REC_W-1:0] e;
    arm();
    for (int i = 0; i < 4; i++) begin
      MEM_MemWrite = 1'b1;
      PC = 32'h200 + 32'(i);
      push_exp(mk_rec(2'd1, 5'd0, 32'd0, PC));
      cycle();
    end
    // Full buffer: pop and push in the same cycle.
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin e = exp0[0]; exp0.delete(0); end
      else begin e = exp1[0]; exp1.delete(0); end
      total++;
      if (rd_valid[d] !== 1'b1 || rd_data[d] !== e) begin
        bad++; $display("[TB] FAIL b2b_head dut%0d: got valid=%b data=%h expected %h", d, rd_valid[d], rd_data[d], e);
      end
    end
    Rd_Ready = 1'b1; PC = 32'h204;
    push_exp(mk_rec(2'd1, 5'd0, 32'd0, 32'h204));
    cycle();
    Rd_Ready = 1'b0;
    idle_events();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd4 || cnt_drop[d] !== 16'd0) begin
        bad++; $display("[TB] FAIL b2b_full_pop dut%0d: got count=%0d drop=%0d expected 4/0", d, count[d], cnt_drop[d]);
      end
    end
    // Enter the post-trigger window, then clear out of it.
    TrigEn = 1'b1; TrigPC = 32'h300; PostCnt = 3'd3;
    ID_DoJump = 1'b1; PC = 32'h300;
    cycle();
    idle_events();
    Clear = 1'b1;
    cycle();
    Clear = 1'b0;
    exp0.delete(); exp1.delete();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd0 || rd_valid[d] !== 1'b0 || frozen[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL clear_in_post dut%0d: got count=%0d valid=%b frozen=%b expected 0/0/0", d, count[d], rd_valid[d], frozen[d]);
      end
      total++;
      if (cnt_evt[d] !== '0 || cnt_drop[d] !== '0) begin
        bad++; $display("[TB] FAIL clear_counters dut%0d: got evt=%h drop=%h expected 0", d, cnt_evt[d], cnt_drop[d]);
      end
    end
    // Cleared back to idle: this event must be ignored.
    ID_DoJump = 1'b1; PC = 32'h300;
    cycle();
    idle_events();
    TrigEn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd0 || cnt_evt[d] !== '0) begin
        bad++; $display("[TB] FAIL clear_idle dut%0d: got count=%0d evt=%h expected 0", d, count[d], cnt_evt[d]);
      end
    end
    // Empty buffer: a pop request alongside a push must not lose the push.
    arm();
    Rd_Ready = 1'b1; MEM_MemWrite = 1'b1; PC = 32'h400;
    push_exp(mk_rec(2'd1, 5'd0, 32'd0, 32'h400));
    cycle();
    idle_events();
    Rd_Ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (count[d] !== 3'd1 || rd_valid[d] !== 1'b1) begin
        bad++; $display("[TB] FAIL empty_push_pop dut%0d: got count=%0d valid=%b expected 1/1", d, count[d], rd_valid[d]);
      end
    end
    Rd_Ready = 1'b1;
    for (int c = 0; c < 12 && (exp0.size() > 0 || exp1.size() > 0); c++) begin
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? exp0.size() : exp1.size();
        if (n > 0) begin
          if (d == 0) begin e = exp0[0]; exp0.delete(0); end
          else begin e = exp1[0]; exp1.delete(0); end
          total++;
          if (rd_valid[d] !== 1'b1 || rd_data[d] !== e) begin
            bad++; $display("[TB] FAIL b2b_drain dut%0d: got valid=%b data=%h expected %h", d, rd_valid[d], rd_data[d], e);
          end
        end
      end
      cycle();
    end
    Rd_Ready = 1'b0;
    do_clear();
  endtask

  initial begin
    Reset = 1'b0; En = 1'b0; Clear = 1'b0; Rd_Ready = 1'b0;
    TrigEn = 1'b0; TrigPC = '0; PostCnt = '0; PC = '0;
    idle_events();
    cycle();
    cycle();
    Reset = 1'b1;
    cycle();
    test_reset();
    test_priority();
    test_full_wrap();
    test_trigger();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
